// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Brief    : Restoring shift-subtract divider, one quotient bit per clock.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             BTN,
   input  logic [WIDTH-1:0] DIVIDEND,
   input  logic [WIDTH-1:0] DIVISOR,
   output logic [WIDTH-1:0] QUOT,
   output logic [WIDTH-1:0] REM,
   output logic             DONE,
   output logic             BUSY,
   output logic             DIV0
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_ZERO  = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   logic [1:0]       r_state;
   logic             r_btn_prev;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_r;
   logic [CNT_W-1:0] r_cnt;

   logic             w_start;
   logic [WIDTH:0]   w_t;
   logic             w_ge;
   logic [WIDTH-1:0] w_r_next;
   logic [WIDTH-1:0] w_q_next;
   logic             w_last;

   assign w_start  = BTN & ~r_btn_prev;
   assign w_t      = {r_r, r_q[WIDTH-1]};
   assign w_ge     = (w_t >= {1'b0, r_d});
   // When the trial subtraction succeeds the difference is below D, so the
   // low WIDTH bits of the wide subtraction are the exact remainder.
   assign w_r_next = w_ge ? (w_t[WIDTH-1:0] - r_d) : w_t[WIDTH-1:0];
   assign w_q_next = {r_q[WIDTH-2:0], w_ge};
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_btn_prev <= 1'b0;
         r_d        <= '0;
         r_q        <= '0;
         r_r        <= '0;
         r_cnt      <= '0;
         QUOT       <= '0;
         REM        <= '0;
         DONE       <= 1'b0;
         BUSY       <= 1'b0;
         DIV0       <= 1'b0;
      end else begin
         r_btn_prev <= BTN;
         case (r_state)
            S_IDLE: begin
               DONE <= 1'b0;
               BUSY <= 1'b0;
               if (w_start) begin
                  r_d   <= DIVISOR;
                  r_q   <= DIVIDEND;
                  r_r   <= '0;
                  r_cnt <= '0;
                  if (DIVISOR == '0) begin
                     r_state <= S_ZERO;
                  end else begin
                     r_state <= S_SHIFT;
                     BUSY    <= 1'b1;
                  end
               end
            end
            S_SHIFT: begin
               r_q   <= w_q_next;
               r_r   <= w_r_next;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  QUOT    <= w_q_next;
                  REM     <= w_r_next;
                  DONE    <= 1'b1;
                  DIV0    <= 1'b0;
                  BUSY    <= 1'b0;
                  r_state <= S_FIN;
               end
            end
            S_ZERO: begin
               // Q still holds the untouched dividend latched at start
               QUOT    <= '1;
               REM     <= r_q;
               DIV0    <= 1'b1;
               DONE    <= 1'b1;
               r_state <= S_FIN;
            end
            S_FIN: begin
               DONE    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               DONE    <= 1'b0;
               BUSY    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Brief    : Directed self-checking bench for seq_divider (WIDTH = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       BTN = 1'b0;
   logic [7:0] DIVIDEND = '0;
   logic [7:0] DIVISOR  = '0;
   logic [7:0] QUOT;
   logic [7:0] REM;
   logic       DONE;
   logic       BUSY;
   logic       DIV0;

   int n_cmp = 0;
   int n_err = 0;

   seq_divider #(.WIDTH(8)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .BTN      (BTN),
      .DIVIDEND (DIVIDEND),
      .DIVISOR  (DIVISOR),
      .QUOT     (QUOT),
      .REM      (REM),
      .DONE     (DONE),
      .BUSY     (BUSY),
      .DIV0     (DIV0)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Start one operation on the current IDLE edge, wait for DONE, check
   // results, latency and BUSY width, then step through FIN back to IDLE.
   task automatic do_op(input int a, input int b, input int eq, input int er,
                        input int ediv0, input int elat, input bit scramble);
      int lat;
      int busy_cnt;
      DIVIDEND = 8'(a);
      DIVISOR  = 8'(b);
      BTN      = 1'b1;
      tick();
      BTN      = 1'b0;
      lat      = 0;
      busy_cnt = BUSY ? 1 : 0;
      check($sformatf("done_early %0d/%0d", a, b), {31'd0, DONE}, 32'd0);
      while (!DONE && lat < 20) begin
         if (scramble) begin
            DIVIDEND = 8'($urandom);
            DIVISOR  = 8'($urandom);
         end
         tick();
         lat++;
         if (BUSY) busy_cnt++;
      end
      check($sformatf("latency %0d/%0d", a, b), lat, elat);
      check($sformatf("busy_cycles %0d/%0d", a, b), busy_cnt, (ediv0 != 0) ? 0 : elat);
      check($sformatf("quot %0d/%0d", a, b), {24'd0, QUOT}, eq);
      check($sformatf("rem %0d/%0d", a, b), {24'd0, REM}, er);
      check($sformatf("div0 %0d/%0d", a, b), {31'd0, DIV0}, ediv0);
      tick();
      check($sformatf("done_pulse %0d/%0d", a, b), {31'd0, DONE}, 32'd0);
   endtask

   initial begin
      int n_done;
      int a;
      int b;

      // Reset state
      tick();
      tick();
      RST = 1'b0;
      check("rst_quot", {24'd0, QUOT}, 0);
      check("rst_rem",  {24'd0, REM}, 0);
      check("rst_done", {31'd0, DONE}, 0);
      check("rst_busy", {31'd0, BUSY}, 0);
      check("rst_div0", {31'd0, DIV0}, 0);
      tick();

      // Basic and edge operands
      do_op(100, 7, 14, 2, 0, 8, 1'b0);
      do_op(255, 1, 255, 0, 0, 8, 1'b0);
      do_op(5, 9, 0, 5, 0, 8, 1'b0);
      do_op(255, 255, 1, 0, 0, 8, 1'b0);
      do_op(0, 13, 0, 0, 0, 8, 1'b0);
      do_op(128, 2, 64, 0, 0, 8, 1'b0);

      // Divide by zero, then a normal operation clears DIV0
      do_op(77, 0, 255, 77, 1, 1, 1'b0);
      do_op(9, 3, 3, 0, 0, 8, 1'b0);

      // Held button produces exactly one operation
      DIVIDEND = 8'd40;
      DIVISOR  = 8'd6;
      BTN      = 1'b1;
      n_done   = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (DONE) n_done++;
      end
      BTN = 1'b0;
      check("held_btn_dones", n_done, 1);
      check("held_btn_quot", {24'd0, QUOT}, 6);
      check("held_btn_rem",  {24'd0, REM}, 4);
      tick();

      // Extra edges mid-SHIFT and during FIN are discarded
      DIVIDEND = 8'd50;
      DIVISOR  = 8'd5;
      BTN      = 1'b1;
      tick();
      BTN = 1'b0;
      tick();
      tick();
      DIVIDEND = 8'd3;
      DIVISOR  = 8'd1;
      BTN      = 1'b1;
      tick();
      BTN = 1'b0;
      n_done = 0;
      while (!DONE && n_done < 20) begin
         tick();
         n_done++;
      end
      check("midshift_latency", n_done + 3, 8);
      check("midshift_quot", {24'd0, QUOT}, 10);
      check("midshift_rem",  {24'd0, REM}, 0);
      BTN = 1'b1;
      tick();
      tick();
      BTN = 1'b0;
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (DONE || BUSY) n_done++;
      end
      check("fin_edge_ignored", n_done, 0);
      check("fin_quot_hold", {24'd0, QUOT}, 10);
      check("fin_rem_hold",  {24'd0, REM}, 0);

      // Reset during iteration 4 abandons the operation
      DIVIDEND = 8'd200;
      DIVISOR  = 8'd3;
      BTN      = 1'b1;
      tick();
      BTN = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("midrst_quot", {24'd0, QUOT}, 0);
      check("midrst_rem",  {24'd0, REM}, 0);
      check("midrst_busy", {31'd0, BUSY}, 0);
      check("midrst_done", {31'd0, DONE}, 0);
      n_done = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (DONE || BUSY) n_done++;
      end
      check("midrst_quiet", n_done, 0);
      do_op(200, 3, 66, 2, 0, 8, 1'b0);

      // Operands scrambled after the start edge
      do_op(123, 10, 12, 3, 0, 8, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      check("hold_quot", {24'd0, QUOT}, 12);
      check("hold_rem",  {24'd0, REM}, 3);

      // Random non-zero-divisor pairs against integer division
      for (int i = 0; i < 300; i++) begin
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(1, 255));
         do_op(a, b, a / b, a % b, 0, 8, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
